// File: rtl/regfile_write_queue_pkg.sv
// Core-wide writeback types shared by the register-file write queue and its forwarding logic.
package regfile_write_queue_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_fwd_match.sv
// Youngest-match search over the queued writes for one register read address.
// Entries are walked oldest to youngest, so the last hit wins.
module regfile_fwd_match
  import regfile_write_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  wb_entry_t [DEPTH-1:0] i_entries,
  input  logic [PW-1:0]         i_head,
  input  logic [CW-1:0]         i_count,
  input  logic [AW-1:0]         i_addr,
  output logic                  o_hit,
  output logic [XLEN-1:0]       o_data
);

  logic [PW-1:0] w_idx;

  // Scan valid slots in age order; x0 never matches.
  always_comb begin
    o_hit  = 1'b0;
    o_data = {XLEN{1'b0}};
    w_idx  = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PW'(i);
      if ((CW'(i) < i_count) && (i_addr != REG_ZERO) && (i_entries[w_idx].rd == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end else begin
        o_hit  = o_hit;
        o_data = o_data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue_sva.sv
// Structural invariants of the register-file write queue.
module regfile_write_queue_sva #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          reset,
  input logic          flush,
  input logic [CW-1:0] count,
  input logic          rf_we,
  input logic          mem_ready,
  input logic          alu_ready
);

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count <= CW'(DEPTH));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
    rf_we |-> (count != {CW{1'b0}}));

  a_flush_quiet: assert property (@(posedge clk) disable iff (!reset)
    flush |-> (!rf_we && !mem_ready && !alu_ready));

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write queue owning the register file write port: merges load and ALU results,
// retires one entry per cycle, and forwards pending values to both decode read ports.
module regfile_write_queue
  import regfile_write_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [AW-1:0]   fwd_a1,
  input  logic [AW-1:0]   fwd_a2,
  output logic            fwd_hit1,
  output logic [XLEN-1:0] fwd_data1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data2,
  output logic [CW-1:0]   count,
  output logic            busy
);

  wb_entry_t [DEPTH-1:0] r_entries;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic          w_mem_acc;
  logic          w_alu_acc;
  logic          w_mem_push;
  logic          w_alu_push;
  logic          w_pop;
  logic [CW-1:0] w_mem_sum;
  logic [PW-1:0] w_alu_slot;

  // Ready ignores the same-cycle pop, so a full queue frees its slot one cycle later.
  assign mem_ready  = !flush && (r_count < CW'(DEPTH));
  assign w_mem_acc  = mem_valid && mem_ready;
  assign w_mem_sum  = r_count + CW'(w_mem_acc);
  assign alu_ready  = !flush && (w_mem_sum < CW'(DEPTH));
  assign w_alu_acc  = alu_valid && alu_ready;

  assign w_mem_push = w_mem_acc && (mem_rd != REG_ZERO);
  assign w_alu_push = w_alu_acc && (alu_rd != REG_ZERO);
  assign w_alu_slot = r_tail + PW'(w_mem_push);

  assign busy     = (r_count != {CW{1'b0}});
  assign count    = r_count;
  assign rf_we    = busy && !flush;
  assign w_pop    = rf_we;
  assign rf_waddr = busy ? r_entries[r_head].rd   : REG_ZERO;
  assign rf_wdata = busy ? r_entries[r_head].data : {XLEN{1'b0}};

  // Entry storage; the load result lands first so the ALU result is the younger one.
  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_entries[r_tail] <= '{rd: mem_rd, data: mem_data};
    end
    if (w_alu_push) begin
      r_entries[w_alu_slot] <= '{rd: alu_rd, data: alu_data};
    end
  end

  // Pointer and occupancy update; flush empties the queue ahead of any push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (flush) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_mem_push) + PW'(w_alu_push);
      r_count <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
    end
  end

  regfile_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_addr    (fwd_a1),
    .o_hit     (fwd_hit1),
    .o_data    (fwd_data1)
  );

  regfile_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_addr    (fwd_a2),
    .o_hit     (fwd_hit2),
    .o_data    (fwd_data2)
  );

  regfile_write_queue_sva #(.DEPTH(DEPTH)) u_sva (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .count     (r_count),
    .rf_we     (rf_we),
    .mem_ready (mem_ready),
    .alu_ready (alu_ready)
  );

endmodule
